// File: rtl/if_id_pkg.sv
// Shared fetch-packet type and bubble constant for the IF/ID queue.
package if_id_pkg;

    localparam int unsigned PKT_ADDR_W = 32;
    localparam int unsigned PKT_INST_W = 32;

    typedef struct packed {
        logic [PKT_ADDR_W-1:0] pc;
        logic [PKT_INST_W-1:0] inst;
        logic                  bp;
        logic [PKT_ADDR_W-1:0] btb_target;
    } fetch_pkt_t;

    // Bubble presented to decode when nothing is queued: all fields zero, inst 0.
    localparam fetch_pkt_t FETCH_PKT_NOP = '0;

endpackage

// File: rtl/if_id_queue_mem.sv
// Packet storage for the IF/ID queue: one write port, one asynchronous read port.
module if_id_queue_mem
    import if_id_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  fetch_pkt_t       wdata,
    input  logic [PTR_W-1:0] raddr,
    output fetch_pkt_t       rdata
);

    fetch_pkt_t mem [DEPTH];

    // Slot contents are only meaningful while occupied, so no reset is needed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Head read is combinational so an entry is visible the cycle after it is written.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: fetch pushes packets, decode pops them in FIFO order.
module if_id_queue
    import if_id_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       if_valid,
    output logic                       if_ready,
    input  logic [ADDR_W-1:0]          PC_if,
    input  logic [INST_W-1:0]          inst_if,
    input  logic                       bp_if,
    input  logic [ADDR_W-1:0]          BTB_target_if,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [ADDR_W-1:0]          PC_id,
    output logic [INST_W-1:0]          inst_id,
    output logic                       bp_id,
    output logic [ADDR_W-1:0]          BTB_target_id,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_enq;
    logic             do_deq;
    fetch_pkt_t       wr_pkt;
    fetch_pkt_t       rd_pkt;
    fetch_pkt_t       head;

    // Handshake qualifiers; if_ready depends only on registered count.
    always_comb begin
        if_ready = (count != CNT_W'(DEPTH));
        id_valid = (count != '0);
        do_enq   = if_valid && if_ready && !flush;
        do_deq   = id_valid && id_ready && !flush;
    end

    // Packet fields are held at the package widths; narrower parameters zero-extend.
    always_comb begin
        wr_pkt.pc         = PKT_ADDR_W'(PC_if);
        wr_pkt.inst       = PKT_INST_W'(inst_if);
        wr_pkt.bp         = bp_if;
        wr_pkt.btb_target = PKT_ADDR_W'(BTB_target_if);
    end

    // Pointer and occupancy update; flush wins over both handshakes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_deq) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_enq, do_deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    if_id_queue_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (do_enq),
        .waddr (wr_ptr),
        .wdata (wr_pkt),
        .raddr (rd_ptr),
        .rdata (rd_pkt)
    );

    // Present the head entry, or a bubble when the queue is empty.
    always_comb begin
        head          = id_valid ? rd_pkt : FETCH_PKT_NOP;
        PC_id         = ADDR_W'(head.pc);
        inst_id       = INST_W'(head.inst);
        bp_id         = head.bp;
        BTB_target_id = ADDR_W'(head.btb_target);
    end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of entries; SHALL be a power of two and at least 2.
REQ-002 Parameter ADDR_W, default 32, PC and BTB target width.
REQ-003 Parameter INST_W, default 32, instruction width.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 flush  input  1  discard every queued entry (redirect or mispredict).
REQ-007 if_valid  input  1  fetch presents an entry.
REQ-008 if_ready  output  1  queue can accept an entry.
REQ-009 PC_if / inst_if / bp_if / BTB_target_if  input  ADDR_W / INST_W / 1 / ADDR_W  fetch payload.
REQ-010 id_valid  output  1  head entry is valid for decode (replaces has_inst).
REQ-011 id_ready  input  1  decode consumes the head; held low by load-use or branch stall.
REQ-012 PC_id / inst_id / bp_id / BTB_target_id  output  ADDR_W / INST_W / 1 / ADDR_W  head payload.
REQ-013 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-014 Enqueue SHALL occur when if_valid && if_ready && !flush at a clock edge.
REQ-015 Dequeue SHALL occur when id_valid && id_ready && !flush at a clock edge.
REQ-016 if_ready SHALL equal (count != DEPTH), registered-state-only, with no combinational path from id_ready.
REQ-017 id_valid SHALL equal (count != 0).
REQ-018 Payload outputs SHALL drive the head entry when id_valid is high, and all-zero (bubble, inst 0) when the queue is empty.
REQ-019 Latency: an entry enqueued at edge N SHALL be visible at the outputs after edge N (one cycle), in strict FIFO order.
REQ-020 Simultaneous enqueue and dequeue SHALL leave count unchanged, advance both pointers, and keep order.
REQ-021 When the queue is full, enqueue SHALL be refused even if a dequeue occurs in the same cycle.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-023 flush SHALL have priority over enqueue and dequeue: the next cycle has count=0, id_valid=0, pointers at 0, and the same-cycle fetch entry is dropped.
REQ-024 With id_ready low and the queue non-empty, head payload and id_valid SHALL hold stable (stall preserve).
REQ-025 Stored entries not at the head SHALL not be observable; contents of freed slots are don't-care.

Reset
REQ-026 Asserting rst SHALL immediately clear count and both pointers and force id_valid=0, if_ready=1, and all payload outputs to 0, including mid-operation.
REQ-027 The first edge after rst deassertion SHALL be able to accept an enqueue.

Structure
REQ-028 A shared package if_id_pkg SHALL hold the fetch_pkt_t struct (pc, inst, bp, btb_target) and the bubble constant FETCH_PKT_NOP.
REQ-029 Storage SHALL be a sub-module if_id_queue_mem (DEPTH x fetch_pkt_t, one write port, one async read port); pointer and count control stays in if_id_queue.

Verification
REQ-030 After reset, enqueue PC 0x00, 0x04, 0x08, 0x0C with id_ready=0 -> count=4, if_ready=0, PC_id=0x00 held.
REQ-031 Full queue, if_valid=1 with PC 0x10 and id_ready=1 -> 0x00 dequeued, 0x10 rejected, count=3, next head 0x04.
REQ-032 count=2, simultaneous enqueue 0x20 and dequeue -> count stays 2, order preserved through 8 enqueues (pointer wrap).
REQ-033 count=3 with flush=1 and if_valid=1 -> next cycle count=0, id_valid=0, inst_id=0, bp_id=0.
REQ-034 rst pulsed asynchronously between edges with count=2 -> outputs zero before the next edge; enqueue of 0x40 succeeds on the first edge after release.
REQ-035 Random if_valid/id_ready/flush for 10k cycles against a reference queue model -> payload order and count match and no overflow or underflow occurs.
